// File: rtl/cfg_latch_sequencer_pkg.sv
// cfg_latch_sequencer_pkg: shared state encoding and CTRL register layout
package cfg_latch_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;
  localparam int IDX_LSB = 0;
  localparam int IDX_W = 5;
  localparam int MODE_BIT = 8;
  localparam int WORD_STRIDE = 4;
endpackage

// File: rtl/cfg_latch_sequencer_gap_timer.sv
// cfg_gap_timer: loadable 4-bit down-counter, expired while the count sits at zero
module cfg_gap_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       expired
);
  logic [3:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 4'd1;
  assign expired = cnt == '0;
endmodule

// File: rtl/cfg_latch_sequencer.sv
// cfg_latch_sequencer: stages a config word from bus writes and strobes it into latch targets
module cfg_latch_sequencer
  import cfg_latch_sequencer_pkg::*;
#(
  parameter int         NUM_REGS   = 8,
  parameter int         CFG_WIDTH  = 80,
  parameter logic [5:0] ADDR_BASE  = 6'h08,
  parameter int         GAP_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 write_req,
  input  logic [31:0]          data_in,
  input  logic [5:0]           address,
  output logic [CFG_WIDTH-1:0] config_data,
  output logic [NUM_REGS-1:0]  latch_en,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);
  localparam int NUM_WORDS = (CFG_WIDTH + 31) / 32;
  localparam int IDX_BITS = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  localparam logic [5:0] CTRL_ADDR = ADDR_BASE + 6'(WORD_STRIDE * NUM_WORDS);
  localparam logic [3:0] NW = 4'(NUM_WORDS);
  localparam logic [5:0] NR = 6'(NUM_REGS);
  localparam logic [IDX_BITS-1:0] TOP_IDX = IDX_BITS'(NUM_REGS - 1);
  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);
  state_t state, state_d;
  logic [IDX_BITS-1:0] idx;
  logic [IDX_W-1:0] ctrl_idx;
  logic [5:0] off;
  logic [CFG_WIDTH-1:0] cfg_d;
  logic [NUM_REGS-1:0] latch_d;
  logic single, expired, last, start, bad_idx, stage_hit, ctrl_hit, timer_load, done_d;
  assign off = address - ADDR_BASE;
  assign stage_hit = write_req && off[1:0] == 2'b00 && off[5:2] < NW;
  assign ctrl_hit = write_req && address == CTRL_ADDR;
  assign ctrl_idx = data_in[IDX_LSB +: IDX_W];
  assign bad_idx = data_in[MODE_BIT] && {1'b0, ctrl_idx} >= NR;
  assign start = ctrl_hit && !busy && !bad_idx;
  assign last = single || idx == '0;
  assign busy = state != IDLE;
  cfg_gap_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (GAP_LOAD),
    .expired  (expired)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_comb
    state_d = state == IDLE  ? (start ? SETUP : IDLE) :
              state == SETUP ? (expired ? PULSE : SETUP) :
              state == PULSE ? HOLD :
              expired ? (last ? IDLE : SETUP) : HOLD;
  // bits of the top word beyond CFG_WIDTH simply have no destination
  always_comb begin
    cfg_d = config_data;
    for (int i = 0; i < CFG_WIDTH; i++)
      if (stage_hit && !busy && i[8:5] == off[5:2]) cfg_d[i] = data_in[i[4:0]];
  end
  always_comb begin
    latch_d = state_d == PULSE ? NUM_REGS'(1) << idx : '0;
    done_d = state == HOLD && expired && last;
    timer_load = state_d != state && (state_d == SETUP || state_d == HOLD);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      config_data <= '0;
      latch_en <= '0;
      done <= 1'b0;
      err <= 1'b0;
      idx <= '0;
      single <= 1'b0;
    end else begin
      config_data <= cfg_d;
      latch_en <= latch_d;
      done <= done_d;
      if (start) begin
        idx <= data_in[MODE_BIT] ? ctrl_idx[IDX_BITS-1:0] : TOP_IDX;
        single <= data_in[MODE_BIT];
      end else if (state == HOLD && expired && !last) idx <= idx - 1'b1;
      if (start) err <= 1'b0;
      else if ((ctrl_hit && (busy || bad_idx)) || (stage_hit && busy)) err <= 1'b1;
    end
endmodule

// File: tb/tb_cfg_latch_sequencer.sv
// tb_cfg_latch_sequencer: checks two configurations against a cycle-offset timing model
module tb_cfg_latch_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic wr_a = 1'b0, wr_b = 1'b0;
  logic [31:0] din_a = '0, din_b = '0;
  logic [5:0] addr_a = '0, addr_b = '0;
  logic [79:0] cfg_a;
  logic [39:0] cfg_b;
  logic [7:0] le_a;
  logic [3:0] le_b;
  logic busy_a, done_a, err_a, busy_b, done_b, err_b;
  int cyc = 0;
  int tests = 0, fails = 0;
  int nr[2] = '{8, 4};
  int gp[2] = '{1, 2};
  int nw[2] = '{3, 2};
  int cw[2] = '{80, 40};
  int base[2] = '{8, 0};
  bit act[2], merr[2];
  int t0[2], first[2], cnt[2];
  logic [127:0] mcfg[2];

  cfg_latch_sequencer dut_a (
    .clk(clk), .rst_n(rst_n), .write_req(wr_a), .data_in(din_a), .address(addr_a),
    .config_data(cfg_a), .latch_en(le_a), .busy(busy_a), .done(done_a), .err(err_a)
  );
  cfg_latch_sequencer #(.NUM_REGS(4), .CFG_WIDTH(40), .ADDR_BASE(6'h00), .GAP_CYCLES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .write_req(wr_b), .data_in(din_b), .address(addr_b),
    .config_data(cfg_b), .latch_en(le_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string n, logic [127:0] a, logic [127:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // expected outputs from the sequence start cycle and the documented pulse spacing
  function automatic void expect_of(int j, int c, output logic [31:0] le, output logic b, output logic dn);
    int s = 2 * gp[j] + 1;
    int d = c - t0[j];
    le = '0; b = 1'b0; dn = 1'b0;
    if (act[j]) begin
      b = d >= 1 && d <= cnt[j] * s;
      dn = d == cnt[j] * s + 1;
      if (d >= 1 + gp[j] && (d - 1 - gp[j]) % s == 0 && (d - 1 - gp[j]) / s < cnt[j])
        le = 32'd1 << (first[j] - (d - 1 - gp[j]) / s);
    end
  endfunction

  task automatic apply(int j, int c, logic w, logic [31:0] d, logic [5:0] a);
    logic [31:0] le;
    logic b, dn;
    int off, ca;
    if (!w) return;
    expect_of(j, c, le, b, dn);
    off = (int'(a) - base[j]) & 63;
    ca = (base[j] + 4 * nw[j]) & 63;
    if (off % 4 == 0 && off / 4 < nw[j]) begin
      if (b) merr[j] = 1'b1;
      else for (int i = 0; i < 32; i++) if (32 * (off / 4) + i < cw[j]) mcfg[j][32 * (off / 4) + i] = d[i];
    end else if (int'(a) == ca) begin
      if (b || (d[8] && int'(d[4:0]) >= nr[j])) merr[j] = 1'b1;
      else begin
        act[j] = 1'b1; t0[j] = c; merr[j] = 1'b0;
        first[j] = d[8] ? int'(d[4:0]) : nr[j] - 1;
        cnt[j] = d[8] ? 1 : nr[j];
      end
    end
  endtask

  initial forever begin
    logic [31:0] le;
    logic b, dn;
    @(negedge clk);
    if (!rst_n) for (int j = 0; j < 2; j++) begin
      act[j] = 1'b0; merr[j] = 1'b0; mcfg[j] = '0;
    end
    expect_of(0, cyc, le, b, dn);
    chk("a_latch", 128'(le_a), 128'(le));
    chk("a_busy", 128'(busy_a), 128'(b));
    chk("a_done", 128'(done_a), 128'(dn));
    chk("a_err", 128'(err_a), 128'(merr[0]));
    chk("a_cfg", 128'(cfg_a), mcfg[0]);
    expect_of(1, cyc, le, b, dn);
    chk("b_latch", 128'(le_b), 128'(le));
    chk("b_busy", 128'(busy_b), 128'(b));
    chk("b_done", 128'(done_b), 128'(dn));
    chk("b_err", 128'(err_b), 128'(merr[1]));
    chk("b_cfg", 128'(cfg_b), mcfg[1]);
    if (rst_n) begin
      apply(0, cyc, wr_a, din_a, addr_a);
      apply(1, cyc, wr_b, din_b, addr_b);
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic at(int x);
    while (cyc < x) tick;
  endtask
  task automatic wa(logic [5:0] a, logic [31:0] d, output int t);
    addr_a = a; din_a = d; wr_a = 1'b1; t = cyc;
    tick;
    wr_a = 1'b0;
  endtask
  task automatic wb(logic [5:0] a, logic [31:0] d, output int t);
    addr_b = a; din_b = d; wr_b = 1'b1; t = cyc;
    tick;
    wr_b = 1'b0;
  endtask

  initial begin
    int t, t2, t3, t4;
    repeat (3) tick;
    chk("rst_latch", 128'(le_a), 128'(0));
    chk("rst_busy", 128'(busy_a), 128'(0));
    chk("rst_cfg", 128'(cfg_a), 128'(0));
    rst_n = 1'b1;
    tick;
    wa(6'h08, 32'h11111111, t);
    wa(6'h0C, 32'h22222222, t);
    wa(6'h10, 32'h00003333, t);
    wa(6'h14, 32'h000, t);
    at(t + 1);
    chk("lit_cfg", 128'(cfg_a), 128'(80'h3333_22222222_11111111));
    chk("lit_busy_t1", 128'(busy_a), 128'(1));
    at(t + 2); chk("lit_p0", 128'(le_a), 128'(8'h80));
    at(t + 5); chk("lit_p1", 128'(le_a), 128'(8'h40));
    at(t + 23); chk("lit_p7", 128'(le_a), 128'(8'h01));
    at(t + 25);
    chk("lit_done", 128'(done_a), 128'(1));
    chk("lit_idle", 128'(busy_a), 128'(0));
    wa(6'h14, 32'h103, t2);
    at(t2 + 2); chk("lit_single", 128'(le_a), 128'(8'h08));
    at(t2 + 4); chk("lit_single_done", 128'(done_a), 128'(1));
    at(t2 + 5);
    wa(6'h14, 32'h109, t);
    chk("lit_bad_busy", 128'(busy_a), 128'(0));
    chk("lit_bad_err", 128'(err_a), 128'(1));
    wa(6'h14, 32'h000, t3);
    chk("lit_err_clr", 128'(err_a), 128'(0));
    at(t3 + 6);
    wa(6'h08, 32'hDEADBEEF, t);
    chk("lit_busy_err", 128'(err_a), 128'(1));
    chk("lit_cfg_kept", 128'(cfg_a), 128'(80'h3333_22222222_11111111));
    at(t3 + 25); chk("lit_mid_done", 128'(done_a), 128'(1));
    at(t3 + 26);
    wa(6'h14, 32'h000, t4);
    at(t4 + 3);
    wa(6'h0C, 32'h55, t);
    at(t4 + 8);
    chk("lit_p2", 128'(le_a), 128'(8'h20));
    #1 rst_n = 1'b0;
    #1;
    chk("async_latch", 128'(le_a), 128'(0));
    chk("async_busy", 128'(busy_a), 128'(0));
    chk("async_cfg", 128'(cfg_a), 128'(0));
    chk("async_err", 128'(err_a), 128'(0));
    tick;
    rst_n = 1'b1;
    tick;
    wa(6'h14, 32'h105, t);
    at(t + 2); chk("lit_restart", 128'(le_a), 128'(8'h20));
    at(t + 4); chk("lit_restart_done", 128'(done_a), 128'(1));
    wb(6'h00, 32'hAAAAAAAA, t);
    wb(6'h04, 32'hFFFFFF5A, t);
    wb(6'h0C, 32'h1, t);
    chk("b_lit_noerr", 128'(err_b), 128'(0));
    wb(6'h08, 32'h000, t);
    chk("b_lit_cfg", 128'(cfg_b), 128'(40'h5A_AAAAAAAA));
    at(t + 3); chk("b_lit_p0", 128'(le_b), 128'(4'h8));
    at(t + 8); chk("b_lit_p1", 128'(le_b), 128'(4'h4));
    at(t + 18); chk("b_lit_p3", 128'(le_b), 128'(4'h1));
    at(t + 21); chk("b_lit_done", 128'(done_b), 128'(1));
    repeat (3) tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
